// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 frame receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // ones_odd is the XOR of the data bits and the received parity bit.
    function automatic logic parity_fail(input int mode, input logic ones_odd);
        if (mode == PAR_ODD)
            return ~ones_odd;
        else if (mode == PAR_EVEN)
            return ones_odd;
        else
            return 1'b0;
    endfunction

endpackage

// File: rtl/ps2_input_filter.sv
// Two-flop synchroniser plus stability filter for one raw PS/2 line.
module ps2_input_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_in,
    output logic level,
    output logic fall
);

    localparam int CW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

    logic [1:0]    sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          fall_q, fall_d;

    // The counter tracks how many samples in a row disagree with the accepted level.
    always_comb begin
        sync_d  = {sync_q[0], raw_in};
        cnt_d   = '0;
        level_d = level_q;
        fall_d  = 1'b0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync_q[1];
                fall_d  = level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            level_q <= 1'b1;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            fall_q  <= fall_d;
        end
    end

    assign level = level_q;
    assign fall  = fall_q;

endmodule

// File: rtl/ps2_frame_receiver.sv
// PS/2 frame receiver: deserialises start/data/parity/stop, checks the frame
// and hands each byte over through a one-entry valid/ready buffer.
module ps2_frame_receiver
    import ps2_pkg::*;
#(
    parameter int DATA_BITS      = 8,
    parameter int PARITY_MODE    = 1,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                 clock_fpga,
    input  logic                 reset,
    input  logic                 clock_intermediar,
    input  logic                 data_in,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CNT_W = $clog2(DATA_BITS + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic clk_level, clk_fall, dat_level, dat_fall;
    logic unused_filter_outs;

    ps2_input_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk    (clock_fpga),
        .rst_n  (reset),
        .raw_in (clock_intermediar),
        .level  (clk_level),
        .fall   (clk_fall)
    );

    ps2_input_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filter (
        .clk    (clock_fpga),
        .rst_n  (reset),
        .raw_in (data_in),
        .level  (dat_level),
        .fall   (dat_fall)
    );

    assign unused_filter_outs = clk_level ^ dat_fall;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_bit_q, par_bit_d;
    logic [TMO_W-1:0]     tmo_q, tmo_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic                 done;

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_bit_d    = par_bit_q;
        tmo_d        = tmo_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        parity_err_d = parity_err_q;
        frame_err_d  = 1'b0;
        overrun_d    = 1'b0;
        done         = 1'b0;

        if (rx_valid_q && rx_ready)
            rx_valid_d = 1'b0;

        if (clk_fall) begin
            tmo_d = '0;
            case (state_q)
                IDLE: begin
                    if (!dat_level) begin
                        bit_cnt_d = '0;
                        state_d   = DATA;
                    end
                end
                DATA: begin
                    shift_d   = {dat_level, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LAST_BIT)
                        state_d = (PARITY_MODE == PAR_NONE) ? STOP : PARITY;
                end
                PARITY: begin
                    par_bit_d = dat_level;
                    state_d   = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (dat_level)
                        done = 1'b1;
                    else
                        frame_err_d = 1'b1;
                end
            endcase
        end else if (state_q != IDLE) begin
            // Stalled bus inside a frame: abort once the gap since the last edge is too long.
            if (tmo_q >= TMO_LAST) begin
                tmo_d       = '0;
                frame_err_d = 1'b1;
                state_d     = IDLE;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end

        if (done) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d    = shift_q;
                parity_err_d = parity_fail(PARITY_MODE, ^{shift_q, par_bit_q});
                rx_valid_d   = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock_fpga or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_bit_q    <= 1'b0;
            tmo_q        <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_bit_q    <= par_bit_d;
            tmo_q        <= tmo_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: doc/ps2_frame_receiver.md
# ps2_frame_receiver

Parametrised PS/2 serial frame receiver and checker in the `clock_fpga` domain. It takes the raw keyboard clock and data lines and synchronises and de-glitches them. It deserialises start, data, optional parity and stop bits, then checks the frame and delivers each byte through a one-entry valid/ready buffer. It generalises the existing frame checker with configurable data width and parity mode, an internal bit counter, a frame timeout and overrun reporting.

## Interface
Parameters:
- `DATA_BITS`, 8: data bits per frame, legal range 5..9, sent LSB first.
- `PARITY_MODE`, 1: 0 = no parity bit, 1 = odd, 2 = even.
- `FILTER_LEN`, 4: consecutive equal synchronised samples required before a line level is accepted; legal range ≥1.
- `TIMEOUT_CYCLES`, 50000: maximum `clock_fpga` cycles between falling edges inside a frame before the frame is aborted.

Ports:
- `clock_fpga`  in  1  system clock; the block uses this one clock only.
- `reset`  in  1  asynchronous, active-low reset.
- `clock_intermediar`  in  1  raw PS/2 clock line, asynchronous.
- `data_in`  in  1  raw PS/2 data line, asynchronous.
- `rx_ready`  in  1  consumer accepts `rx_data` when high together with `rx_valid`.
- `rx_data`  out  DATA_BITS  received data word.
- `rx_valid`  out  1  `rx_data` and `parity_err` hold a received frame.
- `parity_err`  out  1  sideband flag of the buffered frame: its parity check failed.
- `frame_err`  out  1  one-cycle pulse: frame discarded because of a bad stop bit or a timeout.
- `overrun`  out  1  one-cycle pulse: a good frame was dropped because the buffer was full.
- `busy`  out  1  high while a frame is in progress (state ≠ IDLE).

## Operation
- Both raw lines pass through a 2-flop synchroniser and then a stability filter. The filtered level changes only after `FILTER_LEN` consecutive equal samples.
- A falling edge of the filtered clock is a one-cycle strobe `fall`. All bit sampling uses the filtered data on `fall`.
- Frame length is N = DATA_BITS + 2 + (PARITY_MODE≠0).
- FSM states and transitions:
  - IDLE: on `fall` with data 0, clear the bit counter and go to DATA. On `fall` with data 1, stay in IDLE and raise no error (treated as a stray edge).
  - DATA: on each `fall`, shift the bit in at the MSB of the shift register (shift right) and increment the counter. After the `DATA_BITS`-th bit, go to PARITY, or to STOP if `PARITY_MODE`=0.
  - PARITY: on `fall`, capture the parity bit and go to STOP.
  - STOP: on `fall` with data 1, the frame is complete; go to IDLE. On `fall` with data 0, pulse `frame_err`, discard the frame and go to IDLE.
- Parity rule:
  - Odd mode: error if popcount(data) + parity bit is even.
  - Even mode: error if that sum is odd.
  - Mode 0: `parity_err` is always 0.
  - A parity error does not discard the frame; the frame is delivered with `parity_err`=1.
- Timeout: the counter clears on every `fall` and counts in any state other than IDLE. On reaching `TIMEOUT_CYCLES`, pulse `frame_err`, clear the counter and go to IDLE.
- Buffer behaviour on frame completion:
  - If the buffer is empty, or is emptied by a handshake in the same cycle, load `rx_data`/`parity_err` and set `rx_valid`.
  - Otherwise drop the new frame, pulse `overrun`, and leave the old contents unchanged.
- Handshake: `rx_valid` stays high and `rx_data`/`parity_err` stay stable until a cycle with `rx_valid`&&`rx_ready`. In that cycle `rx_valid` clears, unless a completion reloads the buffer in the same cycle.

## Timing
- Reset values: `rx_data`=0, `rx_valid`=0, `parity_err`=0, `frame_err`=0, `overrun`=0, `busy`=0, FSM=IDLE, counters 0, filters at level 1 (idle bus).
- Reset asserted mid-frame abandons the frame with no error pulse. After release, the block waits for a new start bit.
- Input latency: raw edge → `fall` strobe is 2 + `FILTER_LEN` cycles.
- `rx_valid` rises in the cycle after the `fall` that samples a good stop bit. `frame_err` and `overrun` pulse in that same cycle.
- `busy` rises the cycle after the start-bit `fall` and falls with the return to IDLE.
- The bit counter is $clog2(DATA_BITS+1) wide. The timeout counter is $clog2(TIMEOUT_CYCLES+1) wide and saturates; it never wraps.

## Structure
- Package `ps2_pkg`: FSM state typedef (IDLE, DATA, PARITY, STOP) and the parity-mode constants `PAR_NONE`=0, `PAR_ODD`=1, `PAR_EVEN`=2.
- Sub-module `ps2_input_filter`, parameter `FILTER_LEN`:
  - Contains the synchroniser and stability filter for one line.
  - Instantiated twice, once for clock and once for data.
  - The clock instance also generates `fall`.

## Test plan
- Defaults, frame for 0x1C (0, 00111000 LSB first, parity 0, stop 1), `rx_ready`=1 → `rx_valid` for one cycle with `rx_data`=0x1C, `parity_err`=0.
- Same frame with parity 1 → `rx_data`=0x1C, `parity_err`=1, no `frame_err`.
- Frame for 0xF0 with stop bit 0 → one `frame_err` pulse, `rx_valid` stays 0. A following good 0xF0 frame (parity 1) → received correctly.
- Start plus 5 data bits, then the clock is held high for more than `TIMEOUT_CYCLES` → `frame_err` pulse, `busy`=0. A next good 0x1C frame → received correctly.
- `rx_ready`=0, frames 0x1C then 0xF0 → `rx_data`=0x1C held, one `overrun` pulse. Raise `rx_ready` → one handshake, then `rx_valid`=0.
- `FILTER_LEN`=4: a 2-cycle low glitch on `clock_intermediar` in IDLE → no `fall`, `busy` stays 0.
- `DATA_BITS`=7, `PARITY_MODE`=2: frame for 0x55 with parity 0 → `rx_data`=0x55, `parity_err`=0.
